// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI encodings, bus payload types and helpers for the two-master arbiter.
package vscale_hasti_arbiter_pkg;

  localparam int unsigned HASTI_ADDR_WIDTH  = 32;
  localparam int unsigned HASTI_BUS_WIDTH   = 32;
  localparam int unsigned HASTI_SIZE_WIDTH  = 3;
  localparam int unsigned HASTI_BURST_WIDTH = 3;
  localparam int unsigned HASTI_PROT_WIDTH  = 4;
  localparam int unsigned HASTI_TRANS_WIDTH = 2;
  localparam int unsigned HASTI_NUM_MASTERS = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE     = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALFWORD = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD     = 3'd2;

  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'd0;
  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_INCR   = 3'd1;
  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_WRAP4  = 3'd2;
  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_INCR4  = 3'd3;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // Address-phase payload of one master.
  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic                         hmastlock;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
    logic [HASTI_TRANS_WIDTH-1:0] htrans;
  } hasti_ctrl_t;

  // NONSEQ or SEQ both carry a real transfer.
  function automatic logic hasti_is_req(hasti_ctrl_t c);
    return c.htrans[1];
  endfunction

  // Locked or bursting transfers keep the bus for the next address phase.
  function automatic logic hasti_holds_bus(hasti_ctrl_t c);
    return c.hmastlock || (c.hburst != HASTI_BURST_SINGLE);
  endfunction

endpackage

// File: rtl/vscale_hasti_resp_hold.sv
// Per-master parking slot for a read response the master could not accept yet.
module vscale_hasti_resp_hold
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture_i,
  input  logic                       clear_i,
  input  logic [HASTI_BUS_WIDTH-1:0] rdata_i,
  input  logic                       resp_i,
  output logic                       pend_o,
  output logic [HASTI_BUS_WIDTH-1:0] rdata_o,
  output logic                       resp_o
);

  logic                       pend_q, pend_d;
  logic [HASTI_BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                       resp_q, resp_d;

  // Capture wins over clear; the two never coincide in the arbiter.
  always_comb begin
    pend_d  = pend_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (capture_i) begin
      pend_d  = 1'b1;
      rdata_d = rdata_i;
      resp_d  = resp_i;
    end else if (clear_i) begin
      pend_d  = 1'b0;
    end
  end

  // Hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= HASTI_RESP_OKAY;
    end else begin
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign pend_o  = pend_q;
  assign rdata_o = rdata_q;
  assign resp_o  = resp_q;

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Fixed-priority two-master HASTI arbiter in front of a single SRAM slave.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic                         m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic                         m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic                         s_hresp
);

  hasti_ctrl_t m0_ctrl, m1_ctrl, g_ctrl;
  logic        grant, req_g;

  logic last_owner_q, last_owner_d;
  logic dvalid_q, dvalid_d;
  logic downer_q, downer_d;
  logic hold_grant_q, hold_grant_d;

  logic [HASTI_NUM_MASTERS-1:0] req, addr_ok, dphase, capture;
  logic [HASTI_NUM_MASTERS-1:0] pend, hold_resp, hready, hresp;
  logic [HASTI_BUS_WIDTH-1:0]   hold_rdata [HASTI_NUM_MASTERS];
  logic [HASTI_BUS_WIDTH-1:0]   hrdata     [HASTI_NUM_MASTERS];

  assign m0_ctrl = '{haddr: m0_haddr, hwrite: m0_hwrite, hsize: m0_hsize, hburst: m0_hburst,
                     hmastlock: m0_hmastlock, hprot: m0_hprot, htrans: m0_htrans};
  assign m1_ctrl = '{haddr: m1_haddr, hwrite: m1_hwrite, hsize: m1_hsize, hburst: m1_hburst,
                     hmastlock: m1_hmastlock, hprot: m1_hprot, htrans: m1_htrans};

  assign req[0] = hasti_is_req(m0_ctrl);
  assign req[1] = hasti_is_req(m1_ctrl);

  // Grant: frozen on stall or held lock/burst, else port 0 first, else park.
  always_comb begin
    grant = last_owner_q;
    if (s_hready && !hold_grant_q) begin
      if (req[0]) begin
        grant = OWNER_M0;
      end else if (req[1]) begin
        grant = OWNER_M1;
      end
    end
  end

  assign g_ctrl = (grant == OWNER_M1) ? m1_ctrl : m0_ctrl;
  assign req_g  = hasti_is_req(g_ctrl);

  // Address phase is accepted only when the slave is ready.
  always_comb begin
    last_owner_d = last_owner_q;
    dvalid_d     = dvalid_q;
    downer_d     = downer_q;
    hold_grant_d = hold_grant_q;
    if (s_hready) begin
      last_owner_d = grant;
      dvalid_d     = req_g;
      downer_d     = grant;
      hold_grant_d = req_g && hasti_holds_bus(g_ctrl);
    end
  end

  // Arbitration state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_owner_q <= OWNER_M0;
      dvalid_q     <= 1'b0;
      downer_q     <= OWNER_M0;
      hold_grant_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      dvalid_q     <= dvalid_d;
      downer_q     <= downer_d;
      hold_grant_q <= hold_grant_d;
    end
  end

  assign s_haddr     = g_ctrl.haddr;
  assign s_hwrite    = g_ctrl.hwrite;
  assign s_hsize     = g_ctrl.hsize;
  assign s_hburst    = g_ctrl.hburst;
  assign s_hmastlock = g_ctrl.hmastlock;
  assign s_hprot     = g_ctrl.hprot;
  assign s_htrans    = hresetn ? g_ctrl.htrans : HASTI_TRANS_IDLE;
  assign s_hwdata    = (downer_q == OWNER_M1) ? m1_hwdata : m0_hwdata;

  // Per-master ready/response routing, parking a response the master cannot take.
  always_comb begin
    for (int x = 0; x < int'(HASTI_NUM_MASTERS); x++) begin
      addr_ok[x] = !req[x] || ((grant == 1'(x)) && s_hready);
      dphase[x]  = dvalid_q && (downer_q == 1'(x));
      hready[x]  = addr_ok[x];
      hrdata[x]  = s_hrdata;
      hresp[x]   = HASTI_RESP_OKAY;
      capture[x] = 1'b0;
      if (pend[x]) begin
        hrdata[x] = hold_rdata[x];
        hresp[x]  = hold_resp[x];
      end else if (dphase[x]) begin
        hready[x]  = s_hready && addr_ok[x];
        hresp[x]   = s_hresp;
        capture[x] = s_hready && !addr_ok[x];
      end
    end
  end

  vscale_hasti_resp_hold u_hold0 (
    .clk       (hclk),
    .rst_n     (hresetn),
    .capture_i (capture[0]),
    .clear_i   (hready[0]),
    .rdata_i   (s_hrdata),
    .resp_i    (s_hresp),
    .pend_o    (pend[0]),
    .rdata_o   (hold_rdata[0]),
    .resp_o    (hold_resp[0])
  );

  vscale_hasti_resp_hold u_hold1 (
    .clk       (hclk),
    .rst_n     (hresetn),
    .capture_i (capture[1]),
    .clear_i   (hready[1]),
    .rdata_i   (s_hrdata),
    .resp_i    (s_hresp),
    .pend_o    (pend[1]),
    .rdata_o   (hold_rdata[1]),
    .resp_o    (hold_resp[1])
  );

  assign m0_hready = hready[0];
  assign m0_hrdata = hrdata[0];
  assign m0_hresp  = hresp[0];
  assign m1_hready = hready[1];
  assign m1_hrdata = hrdata[1];
  assign m1_hresp  = hresp[1];

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for the two-master HASTI arbiter; the bench plays both masters and the slave.
module tb_vscale_hasti_arbiter;

  logic        hclk;
  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic        m0_hmastlock, m1_hmastlock;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready;
  logic        m0_hresp, m1_hresp;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic        s_hmastlock;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  int checks;
  int errors;

  vscale_hasti_arbiter dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .m0_haddr     (m0_haddr),
    .m0_hwrite    (m0_hwrite),
    .m0_hsize     (m0_hsize),
    .m0_hburst    (m0_hburst),
    .m0_hmastlock (m0_hmastlock),
    .m0_hprot     (m0_hprot),
    .m0_htrans    (m0_htrans),
    .m0_hwdata    (m0_hwdata),
    .m0_hrdata    (m0_hrdata),
    .m0_hready    (m0_hready),
    .m0_hresp     (m0_hresp),
    .m1_haddr     (m1_haddr),
    .m1_hwrite    (m1_hwrite),
    .m1_hsize     (m1_hsize),
    .m1_hburst    (m1_hburst),
    .m1_hmastlock (m1_hmastlock),
    .m1_hprot     (m1_hprot),
    .m1_htrans    (m1_htrans),
    .m1_hwdata    (m1_hwdata),
    .m1_hrdata    (m1_hrdata),
    .m1_hready    (m1_hready),
    .m1_hresp     (m1_hresp),
    .s_haddr      (s_haddr),
    .s_hwrite     (s_hwrite),
    .s_hsize      (s_hsize),
    .s_hburst     (s_hburst),
    .s_hmastlock  (s_hmastlock),
    .s_hprot      (s_hprot),
    .s_htrans     (s_htrans),
    .s_hwdata     (s_hwdata),
    .s_hrdata     (s_hrdata),
    .s_hready     (s_hready),
    .s_hresp      (s_hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Move to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    hresetn = 1'b0;
    m0_haddr = '0; m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_hburst = 3'd0;
    m0_hmastlock = 1'b0; m0_hprot = 4'h3; m0_htrans = 2'd0; m0_hwdata = '0;
    m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = 3'd2; m1_hburst = 3'd0;
    m1_hmastlock = 1'b0; m1_hprot = 4'h3; m1_htrans = 2'd0; m1_hwdata = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;

    // Reset state with idle masters.
    #2;
    chk("rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("rst_m1_hready", 32'(m1_hready), 32'd1);
    chk("rst_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("rst_s_htrans", 32'(s_htrans), 32'd0);
    tick();
    hresetn = 1'b1;
    tick();

    // m1 alone: zero-cycle forwarding, read data next cycle.
    m1_htrans = 2'd2; m1_haddr = 32'h100;
    #1;
    chk("t1_s_haddr", s_haddr, 32'h100);
    chk("t1_s_htrans", 32'(s_htrans), 32'd2);
    chk("t1_m1_hready", 32'(m1_hready), 32'd1);
    tick();
    m1_htrans = 2'd0; s_hrdata = 32'h1122_3344;
    #1;
    chk("t1_m1_hrdata", m1_hrdata, 32'h1122_3344);
    chk("t1_m1_hready_d", 32'(m1_hready), 32'd1);
    tick();

    // Contention with last_owner=1: port 0 still wins, m1 stalls one cycle.
    m0_htrans = 2'd2; m0_haddr = 32'h40; m0_hwrite = 1'b1;
    m1_htrans = 2'd2; m1_haddr = 32'h80;
    #1;
    chk("t2_s_haddr_m0", s_haddr, 32'h40);
    chk("t2_s_hwrite", 32'(s_hwrite), 32'd1);
    chk("t2_m0_hready", 32'(m0_hready), 32'd1);
    chk("t2_m1_stall", 32'(m1_hready), 32'd0);
    tick();
    m0_htrans = 2'd0; m0_hwrite = 1'b0; m0_hwdata = 32'hCAFE_F00D;
    #1;
    chk("t2_s_haddr_m1", s_haddr, 32'h80);
    chk("t2_s_hwdata", s_hwdata, 32'hCAFE_F00D);
    chk("t2_m1_hready", 32'(m1_hready), 32'd1);
    chk("t2_m0_wdone", 32'(m0_hready), 32'd1);
    tick();
    m1_htrans = 2'd0; s_hrdata = 32'h5566_7788;
    #1;
    chk("t2_m1_hrdata", m1_hrdata, 32'h5566_7788);
    tick();

    // Held read response for m1 when it loses arbitration in its data-phase cycle.
    m1_htrans = 2'd2; m1_haddr = 32'h84;
    #1;
    chk("t3_s_haddr_84", s_haddr, 32'h84);
    tick();
    m1_htrans = 2'd2; m1_haddr = 32'h88;
    m0_htrans = 2'd2; m0_haddr = 32'h44;
    s_hrdata = 32'hDEAD_BEEF;
    #1;
    chk("t3_m1_hready_lost", 32'(m1_hready), 32'd0);
    chk("t3_m0_hready", 32'(m0_hready), 32'd1);
    chk("t3_s_haddr_44", s_haddr, 32'h44);
    tick();
    m0_htrans = 2'd0; s_hrdata = 32'h1234_5678;
    #1;
    chk("t3_m1_hready_pend", 32'(m1_hready), 32'd1);
    chk("t3_m1_hrdata_held", m1_hrdata, 32'hDEAD_BEEF);
    chk("t3_m0_hrdata", m0_hrdata, 32'h1234_5678);
    chk("t3_s_haddr_88", s_haddr, 32'h88);
    tick();
    m1_htrans = 2'd0; s_hrdata = 32'hA5A5_A5A5;
    #1;
    chk("t3_m1_hrdata_live", m1_hrdata, 32'hA5A5_A5A5);
    tick();

    // m1 INCR4 burst keeps the bus; m0 granted only after the hold clears.
    m1_htrans = 2'd2; m1_haddr = 32'h200; m1_hburst = 3'd3;
    #1;
    chk("t4_beat0", s_haddr, 32'h200);
    tick();
    m1_htrans = 2'd3; m1_haddr = 32'h204;
    m0_htrans = 2'd2; m0_haddr = 32'h50;
    #1;
    chk("t4_beat1", s_haddr, 32'h204);
    chk("t4_beat1_trans", 32'(s_htrans), 32'd3);
    chk("t4_m0_wait1", 32'(m0_hready), 32'd0);
    tick();
    m1_haddr = 32'h208;
    #1;
    chk("t4_beat2", s_haddr, 32'h208);
    chk("t4_m0_wait2", 32'(m0_hready), 32'd0);
    tick();
    m1_haddr = 32'h20C;
    #1;
    chk("t4_beat3", s_haddr, 32'h20C);
    chk("t4_m0_wait3", 32'(m0_hready), 32'd0);
    tick();
    m1_htrans = 2'd0;
    #1;
    chk("t4_tail_trans", 32'(s_htrans), 32'd0);
    chk("t4_m0_wait_tail", 32'(m0_hready), 32'd0);
    tick();
    m1_hburst = 3'd0;
    #1;
    chk("t4_m0_granted", s_haddr, 32'h50);
    chk("t4_m0_hready", 32'(m0_hready), 32'd1);
    tick();

    // Slave wait states freeze grant and outputs while m1 requests.
    m0_htrans = 2'd0;
    m1_htrans = 2'd2; m1_haddr = 32'h90;
    s_hready = 1'b0;
    #1;
    chk("t5_ws1_s_haddr", s_haddr, 32'h50);
    chk("t5_ws1_m1_hready", 32'(m1_hready), 32'd0);
    chk("t5_ws1_m0_hready", 32'(m0_hready), 32'd0);
    tick();
    #1;
    chk("t5_ws2_s_haddr", s_haddr, 32'h50);
    chk("t5_ws2_m1_hready", 32'(m1_hready), 32'd0);
    tick();
    s_hready = 1'b1; s_hrdata = 32'h0BAD_F00D;
    #1;
    chk("t5_m0_hready", 32'(m0_hready), 32'd1);
    chk("t5_m0_hrdata", m0_hrdata, 32'h0BAD_F00D);
    chk("t5_m1_hready", 32'(m1_hready), 32'd1);
    chk("t5_s_haddr_90", s_haddr, 32'h90);
    tick();

    // Two-cycle ERROR response on m1's data phase.
    m1_htrans = 2'd0; s_hready = 1'b0; s_hresp = 1'b1;
    #1;
    chk("t5_err1_hready", 32'(m1_hready), 32'd0);
    chk("t5_err1_hresp", 32'(m1_hresp), 32'd1);
    chk("t5_err1_m0_hresp", 32'(m0_hresp), 32'd0);
    tick();
    s_hready = 1'b1;
    #1;
    chk("t5_err2_hready", 32'(m1_hready), 32'd1);
    chk("t5_err2_hresp", 32'(m1_hresp), 32'd1);
    tick();

    // Asynchronous reset in the middle of an m0 data phase.
    s_hresp = 1'b0;
    m0_htrans = 2'd2; m0_haddr = 32'h60;
    #1;
    chk("t6_m0_addr", 32'(m0_hready), 32'd1);
    tick();
    m0_htrans = 2'd0; s_hready = 1'b0; s_hresp = 1'b1;
    #1;
    chk("t6_pre_m0_hready", 32'(m0_hready), 32'd0);
    chk("t6_pre_m0_hresp", 32'(m0_hresp), 32'd1);
    #2;
    hresetn = 1'b0;
    m1_htrans = 2'd2; m1_haddr = 32'h300; s_hready = 1'b1;
    #1;
    chk("t6_rst_s_htrans", 32'(s_htrans), 32'd0);
    chk("t6_rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("t6_rst_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("t6_rst_m1_hresp", 32'(m1_hresp), 32'd0);
    tick();
    chk("t6_rst_edge_s_htrans", 32'(s_htrans), 32'd0);
    chk("t6_rst_edge_m0_hresp", 32'(m0_hresp), 32'd0);
    m1_htrans = 2'd0; s_hresp = 1'b0;
    hresetn = 1'b1;
    tick();
    chk("t6_post_park_m0", s_haddr, 32'h60);
    chk("t6_post_m0_hready", 32'(m0_hready), 32'd1);
    chk("t6_post_m1_hready", 32'(m1_hready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
